// File: rtl/apb_req_master_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// apb_req_master_if
// Bundles the two bus-facing sides of apb_req_master:
//   - command channel   : cmd_valid / cmd_ready / cmd_write / cmd_addr / cmd_wdata
//   - response channel  : rsp_valid / rsp_ready / rsp_rdata / rsp_err
//   - APB3 master port  : psel / penable / paddr / pwrite / pwdata / prdata / pready
// Modports:
//   master : the view used by apb_req_master itself (accepts commands,
//            returns responses, drives the APB request signals)
//   slave  : the opposite view, used by whatever surrounds the requester
//            (command source, response sink and the APB slave)
// Clock and reset are deliberately not part of the interface; they stay
// plain ports on the modules.
// ---------------------------------------------------------------------------
interface apb_req_master_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);

   // command channel
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;

   // response channel
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   // APB bus
   logic                  psel;
   logic                  penable;
   logic [ADDR_WIDTH-1:0] paddr;
   logic                  pwrite;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;

   modport master (
      input  cmd_valid,
      input  cmd_write,
      input  cmd_addr,
      input  cmd_wdata,
      output cmd_ready,
      output rsp_valid,
      input  rsp_ready,
      output rsp_rdata,
      output rsp_err,
      output psel,
      output penable,
      output paddr,
      output pwrite,
      output pwdata,
      input  prdata,
      input  pready
   );

   modport slave (
      output cmd_valid,
      output cmd_write,
      output cmd_addr,
      output cmd_wdata,
      input  cmd_ready,
      input  rsp_valid,
      output rsp_ready,
      input  rsp_rdata,
      input  rsp_err,
      input  psel,
      input  penable,
      input  paddr,
      input  pwrite,
      input  pwdata,
      output prdata,
      output pready
   );

endinterface

// File: rtl/apb_req_master.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// apb_req_master
// Upstream APB requester. Takes single read/write commands on a valid/ready
// channel, runs each as one APB3 SETUP/ACCESS transfer and returns the result
// on a valid/ready response channel. A PREADY timeout guarantees that a dead
// or unselected slave cannot hang the requester.
//
// Parameters
//   ADDR_WIDTH      width of cmd_addr / paddr
//   DATA_WIDTH      width of cmd_wdata / pwdata / prdata / rsp_rdata
//   TIMEOUT_CYCLES  max ACCESS cycles spent waiting for pready (0 = never)
//
// Ports
//   clk     in   clock, everything on the rising edge
//   arst_n  in   asynchronous active-low reset
//   bus     --   apb_req_master_if.master
//                  cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata  command in
//                  rsp_valid/rsp_ready/rsp_rdata/rsp_err             response out
//                  psel/penable/paddr/pwrite/pwdata                  APB request
//                  prdata/pready                                     APB reply
//
// Only one transfer is ever in flight. psel always drops for at least the
// RESP cycle between transfers so the slave returns to its idle state.
// ---------------------------------------------------------------------------
module apb_req_master #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              arst_n,
   apb_req_master_if.master  bus
);

   // The counter must be able to hold TIMEOUT_CYCLES itself; with the
   // timeout disabled a single bit keeps the logic legal and is never used
   // to end a transfer.
   localparam int CNT_W        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int TMO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] TMO_LAST = TMO_LAST_INT[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam bit   TMO_EN = (TIMEOUT_CYCLES > 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t state;
   state_t state_nxt;

   // registered transfer context and response
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic                  pwrite_q;
   logic [DATA_WIDTH-1:0] pwdata_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;
   logic                  rsp_err_q;
   logic [CNT_W-1:0]      tmo_cnt;

   // decoded controls from the next-state logic
   logic cmd_ready_c;
   logic psel_c;
   logic penable_c;
   logic rsp_valid_c;
   logic capture_cmd;
   logic complete_ok;
   logic complete_tmo;
   logic tmo_hit;

   // The counter holds the number of ACCESS cycles already finished, so the
   // current ACCESS cycle is the last one allowed when it equals
   // TIMEOUT_CYCLES-1; the transfer then ends on this edge unless pready
   // arrives at the same time.
   assign tmo_hit = TMO_EN && (tmo_cnt >= TMO_LAST);

   // State register. Reset is asynchronous so an in-flight transfer is
   // abandoned and the APB bus released without waiting for a clock.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and output decode. All bus-level control outputs come
   // straight from the state so they change with the state register,
   // including during asynchronous reset. pready is looked at only in
   // ACCESS, so whatever the slave drives outside ACCESS has no effect.
   always_comb begin
      state_nxt    = state;
      cmd_ready_c  = 1'b0;
      psel_c       = 1'b0;
      penable_c    = 1'b0;
      rsp_valid_c  = 1'b0;
      capture_cmd  = 1'b0;
      complete_ok  = 1'b0;
      complete_tmo = 1'b0;

      case (state)
         ST_IDLE: begin
            cmd_ready_c = 1'b1;
            if (bus.cmd_valid) begin
               capture_cmd = 1'b1;
               state_nxt   = ST_SETUP;
            end
         end

         ST_SETUP: begin
            psel_c    = 1'b1;
            state_nxt = ST_ACCESS;
         end

         ST_ACCESS: begin
            psel_c    = 1'b1;
            penable_c = 1'b1;
            // pready takes priority over a timeout landing on the same edge
            if (bus.pready) begin
               complete_ok = 1'b1;
               state_nxt   = ST_RESP;
            end else if (tmo_hit) begin
               complete_tmo = 1'b1;
               state_nxt    = ST_RESP;
            end
         end

         ST_RESP: begin
            rsp_valid_c = 1'b1;
            if (bus.rsp_ready) begin
               state_nxt = ST_IDLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Transfer context. paddr/pwrite/pwdata are loaded only on command
   // acceptance in IDLE, so they cannot move while psel is high and simply
   // hold their last value between transfers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
      end else if (capture_cmd) begin
         paddr_q  <= bus.cmd_addr;
         pwrite_q <= bus.cmd_write;
         pwdata_q <= bus.cmd_wdata;
      end
   end

   // Response registers. They are only written when ACCESS finishes, which
   // keeps them stable for the whole RESP phase however long rsp_ready
   // stays low. Writes and timeouts report zero data.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else if (complete_ok) begin
         rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
         rsp_err_q   <= 1'b0;
      end else if (complete_tmo) begin
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b1;
      end
   end

   // Timeout counter. Cleared as the command is accepted, counts every
   // ACCESS cycle and saturates rather than wrapping, so a disabled or
   // very long wait can never alias back to a small count.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         tmo_cnt <= '0;
      end else if (capture_cmd) begin
         tmo_cnt <= '0;
      end else if ((state == ST_ACCESS) && (tmo_cnt != CNT_MAX)) begin
         tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
   end

   assign bus.cmd_ready = cmd_ready_c;
   assign bus.rsp_valid = rsp_valid_c;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.psel      = psel_c;
   assign bus.penable   = penable_c;
   assign bus.paddr     = paddr_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.pwdata    = pwdata_q;

endmodule
